// File: rtl/sap2_tstate_sequencer_if.sv
// Handshake/bus bundle between the SAP-2 T-state sequencer and its datapath.
// The master side owns the IR and memory-ready inputs; the slave is the sequencer.
interface sap2_tstate_sequencer_if;
  logic [7:0]  iOpcode;
  logic        iMemReady;
  logic [5:0]  oT;
  logic [15:0] oCon;
  logic        oInstrDone;
  logic        oHalt;
  logic        oIllegal;

  modport master (
    output iOpcode,
    output iMemReady,
    input  oT,
    input  oCon,
    input  oInstrDone,
    input  oHalt,
    input  oIllegal
  );

  modport slave (
    input  iOpcode,
    input  iMemReady,
    output oT,
    output oCon,
    output oInstrDone,
    output oHalt,
    output oIllegal
  );
endinterface

// File: rtl/sap2_tstate_sequencer.sv
// SAP-2 controller-sequencer: variable-length T-state machine (falling-edge state)
// producing the one-hot T-state and the 16-bit datapath control word.
module sap2_tstate_sequencer (
  input  logic                     iClk,
  input  logic                     iReset,
  sap2_tstate_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_T1   = 3'd0,
    ST_T2   = 3'd1,
    ST_T3   = 3'd2,
    ST_T4   = 3'd3,
    ST_T5   = 3'd4,
    ST_T6   = 3'd5,
    ST_HALT = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MOVAB = 4'd1,
    OP_MOVBA = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_INR   = 4'd5,
    OP_DCR   = 4'd6,
    OP_MVIA  = 4'd7,
    OP_MVIB  = 4'd8,
    OP_OUT   = 4'd9,
    OP_HLT   = 4'd10,
    OP_ILL   = 4'd11
  } opClass_t;

  localparam logic [15:0] CP  = 16'h0001;
  localparam logic [15:0] EP  = 16'h0002;
  localparam logic [15:0] LM  = 16'h0004;
  localparam logic [15:0] CE  = 16'h0008;
  localparam logic [15:0] LI  = 16'h0010;
  localparam logic [15:0] LA  = 16'h0020;
  localparam logic [15:0] EA  = 16'h0040;
  localparam logic [15:0] SU  = 16'h0080;
  localparam logic [15:0] EU  = 16'h0100;
  localparam logic [15:0] LB  = 16'h0200;
  localparam logic [15:0] EB  = 16'h0400;
  localparam logic [15:0] LO  = 16'h0800;
  localparam logic [15:0] LT  = 16'h1000;
  localparam logic [15:0] INC = 16'h2000;
  localparam logic [15:0] DEC = 16'h4000;

  function automatic opClass_t decodeOp(input logic [7:0] op);
    case (op)
      8'h00:   decodeOp = OP_NOP;
      8'h78:   decodeOp = OP_MOVAB;
      8'h47:   decodeOp = OP_MOVBA;
      8'h80:   decodeOp = OP_ADD;
      8'h90:   decodeOp = OP_SUB;
      8'h3C:   decodeOp = OP_INR;
      8'h3D:   decodeOp = OP_DCR;
      8'h3E:   decodeOp = OP_MVIA;
      8'h06:   decodeOp = OP_MVIB;
      8'hD3:   decodeOp = OP_OUT;
      8'h76:   decodeOp = OP_HLT;
      default: decodeOp = OP_ILL;
    endcase
  endfunction

  function automatic logic [5:0] toOneHot(input state_t s);
    case (s)
      ST_T1:   toOneHot = 6'b000001;
      ST_T2:   toOneHot = 6'b000010;
      ST_T3:   toOneHot = 6'b000100;
      ST_T4:   toOneHot = 6'b001000;
      ST_T5:   toOneHot = 6'b010000;
      ST_T6:   toOneHot = 6'b100000;
      default: toOneHot = 6'b000000;
    endcase
  endfunction

  state_t     state;
  state_t     nextState;
  opClass_t   opClass;
  logic [5:0] tReg;
  logic       haltReg;
  logic       illegalReg;
  logic [15:0] con;
  logic       done;

  // Next-state and done decode; stalls hold T3 and the MVI memory-read T6.
  always_comb begin
    opClass   = decodeOp(bus.iOpcode);
    nextState = ST_T1;
    done      = 1'b0;
    case (state)
      ST_T1: nextState = ST_T2;
      ST_T2: nextState = ST_T3;
      ST_T3: begin
        if (bus.iMemReady) begin
          nextState = ST_T4;
        end else begin
          nextState = ST_T3;
        end
      end
      ST_T4: begin
        case (opClass)
          OP_ADD, OP_SUB, OP_MVIA, OP_MVIB, OP_OUT: nextState = ST_T5;
          OP_HLT: begin
            nextState = ST_HALT;
            done      = 1'b1;
          end
          default: begin
            nextState = ST_T1;
            done      = 1'b1;
          end
        endcase
      end
      ST_T5: begin
        case (opClass)
          OP_MVIA, OP_MVIB, OP_OUT: nextState = ST_T6;
          default: begin
            nextState = ST_T1;
            done      = 1'b1;
          end
        endcase
      end
      ST_T6: begin
        case (opClass)
          OP_MVIA, OP_MVIB: begin
            if (bus.iMemReady) begin
              nextState = ST_T1;
              done      = 1'b1;
            end else begin
              nextState = ST_T6;
              done      = 1'b0;
            end
          end
          default: begin
            nextState = ST_T1;
            done      = 1'b1;
          end
        endcase
      end
      ST_HALT: nextState = ST_HALT;
      default: nextState = ST_T1;
    endcase
  end

  // Control word: fixed fetch words in T1-T3, opcode-decoded words in T4-T6.
  always_comb begin
    con = 16'h0000;
    case (state)
      ST_T1: con = EP | LM;
      ST_T2: con = CP;
      ST_T3: con = CE | LI;
      ST_T4: begin
        case (opClass)
          OP_MOVAB:                 con = EB | LA;
          OP_MOVBA:                 con = EA | LB;
          OP_ADD, OP_SUB:           con = EB | LT;
          OP_INR:                   con = INC | EU | LA;
          OP_DCR:                   con = DEC | EU | LA;
          OP_MVIA, OP_MVIB, OP_OUT: con = EP | LM;
          default:                  con = 16'h0000;
        endcase
      end
      ST_T5: begin
        case (opClass)
          OP_ADD:                   con = EU | LA;
          OP_SUB:                   con = SU | EU | LA;
          OP_MVIA, OP_MVIB, OP_OUT: con = CP;
          default:                  con = 16'h0000;
        endcase
      end
      ST_T6: begin
        case (opClass)
          OP_MVIA: con = CE | LA;
          OP_MVIB: con = CE | LB;
          OP_OUT:  con = EA | LO;
          default: con = 16'h0000;
        endcase
      end
      default: con = 16'h0000;
    endcase
  end

  // State register with registered one-hot T, halt and sticky illegal flags.
  always_ff @(negedge iClk or posedge iReset) begin
    if (iReset) begin
      state      <= ST_T1;
      tReg       <= 6'b000001;
      haltReg    <= 1'b0;
      illegalReg <= 1'b0;
    end else begin
      state   <= nextState;
      tReg    <= toOneHot(nextState);
      haltReg <= (nextState == ST_HALT);
      if ((state == ST_T4) && (opClass == OP_ILL)) begin
        illegalReg <= 1'b1;
      end else begin
        illegalReg <= illegalReg;
      end
    end
  end

  assign bus.oT         = tReg;
  assign bus.oCon       = con;
  assign bus.oInstrDone = done;
  assign bus.oHalt      = haltReg;
  assign bus.oIllegal   = illegalReg;

endmodule
